// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore FSM sequencing a shared multi-cycle datapath (memory, ALU, register
// file, PC, IR). Each instruction takes 2 to 5 cycles depending on its class.
// All outputs are decoded from the state register. The exceptions are the
// BRANCH pcen, which follows `zero`, and the DECODE illegal pulse, which
// depends on the IR-held Op/funct.
// Optional feature: define MEM_HANDSHAKE_EN to stall FETCH/MEMRD/MEMWR on
// mem_ready. When it is undefined, mem_ready is ignored.

module multicycle_controller #(
  parameter int ALUCS_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memread,
  output logic               wren,
  output logic               irwrite,
  output logic               regwrite,
  output logic               redges,
  output logic               memtoreg,
  output logic               selscrA,
  output logic [1:0]         selscrB,
  output logic [1:0]         pcsrc,
  output logic [ALUCS_W-1:0] alucs,
  output logic               flagwrite,
  output logic               instr_done,
  output logic               illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    IEXEC  = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [ALUCS_W-1:0] ALU_AND = ALUCS_W'(0);
  localparam logic [ALUCS_W-1:0] ALU_ADD = ALUCS_W'(2);
  localparam logic [ALUCS_W-1:0] ALU_SUB = ALUCS_W'(3);
  localparam logic [ALUCS_W-1:0] ALU_SLT = ALUCS_W'(4);

  state_t state_q;
  state_t state_d;
  logic   ready_s;

`ifdef MEM_HANDSHAKE_EN
  assign ready_s = mem_ready;
`else
  // Memory always completes in one cycle; mem_ready is deliberately unused.
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign ready_s            = 1'b1;
`endif

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: decode dispatch and memory-state stalls.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        if (ready_s) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (Op)
          OP_RTYPE: begin
            if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT)) begin
              state_d = REXEC;
            end else begin
              state_d = FETCH;
            end
          end
          OP_LW, OP_SW:                state_d = MEMADR;
          OP_ADDI, OP_ADDIU, OP_ANDI:  state_d = IEXEC;
          OP_BEQ, OP_BNE:              state_d = BRANCH;
          OP_J:                        state_d = JUMP;
          default:                     state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (Op == OP_LW) begin
          state_d = MEMRD;
        end else begin
          state_d = MEMWR;
        end
      end
      MEMRD: begin
        if (ready_s) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMWR: begin
        if (ready_s) begin
          state_d = FETCH;
        end else begin
          state_d = MEMWR;
        end
      end
      REXEC:   state_d = RWB;
      IEXEC:   state_d = IWB;
      default: state_d = FETCH;
    endcase
  end

  // Output decode from the state register; everything is forced low during reset.
  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    wren       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    redges     = 1'b0;
    memtoreg   = 1'b0;
    selscrA    = 1'b0;
    selscrB    = 2'd0;
    pcsrc      = 2'd0;
    alucs      = ALU_AND;
    flagwrite  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      pcen = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          memread = 1'b1;
          irwrite = ready_s;
          selscrB = 2'd1;
          alucs   = ALU_ADD;
          pcen    = ready_s;
        end
        DECODE: begin
          // PC + (imm << 2) lands in ALUOut for a possible branch.
          selscrB = 2'd3;
          alucs   = ALU_ADD;
          case (Op)
            OP_RTYPE: begin
              if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT)) begin
                illegal = 1'b0;
              end else begin
                illegal = 1'b1;
              end
            end
            OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_ANDI, OP_BEQ, OP_BNE, OP_J: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          selscrA = 1'b1;
          selscrB = 2'd2;
          alucs   = ALU_ADD;
        end
        MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          wren       = 1'b1;
          iord       = 1'b1;
          instr_done = ready_s;
        end
        REXEC: begin
          selscrA   = 1'b1;
          flagwrite = 1'b1;
          case (funct)
            FN_SUB:  alucs = ALU_SUB;
            FN_SLT:  alucs = ALU_SLT;
            default: alucs = ALU_ADD;
          endcase
        end
        RWB: begin
          regwrite   = 1'b1;
          redges     = 1'b1;
          instr_done = 1'b1;
        end
        IEXEC: begin
          selscrA   = 1'b1;
          selscrB   = 2'd2;
          flagwrite = 1'b1;
          if (Op == OP_ANDI) begin
            alucs = ALU_AND;
          end else begin
            alucs = ALU_ADD;
          end
        end
        IWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          selscrA    = 1'b1;
          alucs      = ALU_SUB;
          pcsrc      = 2'd1;
          instr_done = 1'b1;
          pcen       = ((Op == OP_BEQ) && zero) || ((Op == OP_BNE) && !zero);
        end
        JUMP: begin
          pcsrc      = 2'd2;
          pcen       = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          pcen = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (default build, no handshake).
// Instructions are issued back to back. The reference model predicts the
// control vector from the instruction class and the cycle index within the
// instruction.

module tb_multicycle_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       wren;
    logic       irwrite;
    logic       regwrite;
    logic       redges;
    logic       memtoreg;
    logic       selscrA;
    logic [1:0] selscrB;
    logic [1:0] pcsrc;
    logic [4:0] alucs;
    logic       flagwrite;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_J, C_ILL} cls_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, iord, memread, wren, irwrite, regwrite, redges, memtoreg;
  logic       selscrA, flagwrite, instr_done, illegal;
  logic [1:0] selscrB, pcsrc;
  logic [4:0] alucs;
  outs_t      obs;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.ALUCS_W(5)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memread(memread), .wren(wren), .irwrite(irwrite),
    .regwrite(regwrite), .redges(redges), .memtoreg(memtoreg), .selscrA(selscrA),
    .selscrB(selscrB), .pcsrc(pcsrc), .alucs(alucs), .flagwrite(flagwrite),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, iord, memread, wren, irwrite, regwrite, redges, memtoreg,
                selscrA, selscrB, pcsrc, alucs, flagwrite, instr_done, illegal};

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'd32 || fn == 6'd34 || fn == 6'd42) return C_R;
      return C_ILL;
    end
    if (op == 6'd35) return C_LW;
    if (op == 6'd43) return C_SW;
    if (op == 6'd8 || op == 6'd9 || op == 6'd12) return C_I;
    if (op == 6'd4 || op == 6'd5) return C_BR;
    if (op == 6'd2) return C_J;
    return C_ILL;
  endfunction

  function automatic int length_of(input cls_t c);
    case (c)
      C_LW:          return 5;
      C_SW, C_R, C_I: return 4;
      C_BR, C_J:     return 3;
      default:       return 2;
    endcase
  endfunction

  // Expected control vector for cycle k (0 = first fetch cycle) of an instruction.
  function automatic outs_t expect_out(input logic [5:0] op, input logic [5:0] fn,
                                       input int k, input logic z);
    outs_t o;
    cls_t  c;
    o = '0;
    c = classify(op, fn);
    if (k == 0) begin
      o.memread = 1'b1; o.irwrite = 1'b1; o.selscrB = 2'd1; o.alucs = 5'd2; o.pcen = 1'b1;
    end else if (k == 1) begin
      o.selscrB = 2'd3; o.alucs = 5'd2; o.illegal = (c == C_ILL);
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin
            o.selscrA = 1'b1; o.selscrB = 2'd2; o.alucs = 5'd2;
          end else if (c == C_SW) begin
            o.wren = 1'b1; o.iord = 1'b1; o.instr_done = 1'b1;
          end else if (k == 3) begin
            o.memread = 1'b1; o.iord = 1'b1;
          end else begin
            o.regwrite = 1'b1; o.memtoreg = 1'b1; o.instr_done = 1'b1;
          end
        end
        C_R: begin
          if (k == 2) begin
            o.selscrA = 1'b1; o.flagwrite = 1'b1;
            o.alucs = (fn == 6'd32) ? 5'd2 : ((fn == 6'd34) ? 5'd3 : 5'd4);
          end else begin
            o.regwrite = 1'b1; o.redges = 1'b1; o.instr_done = 1'b1;
          end
        end
        C_I: begin
          if (k == 2) begin
            o.selscrA = 1'b1; o.selscrB = 2'd2; o.flagwrite = 1'b1;
            o.alucs = (op == 6'd12) ? 5'd0 : 5'd2;
          end else begin
            o.regwrite = 1'b1; o.instr_done = 1'b1;
          end
        end
        C_BR: begin
          o.selscrA = 1'b1; o.alucs = 5'd3; o.pcsrc = 2'd1; o.instr_done = 1'b1;
          o.pcen = (op == 6'd4) ? z : ~z;
        end
        C_J: begin
          o.pcsrc = 2'd2; o.pcen = 1'b1; o.instr_done = 1'b1;
        end
        default: o = '0;
      endcase
    end
    return o;
  endfunction

  // Runs one full instruction starting in FETCH; zsel 0/1 forces zero, 2 randomizes it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
    cls_t  c;
    outs_t e;
    int    n_wr, n_rw, n_done, n_ill;
    c = classify(op, fn);
    n_wr = 0; n_rw = 0; n_done = 0; n_ill = 0;
    for (int k = 0; k < length_of(c); k++) begin
      @(negedge clk);
      if (k == 0) begin
        Op = op;
        funct = fn;
      end
      zero = (zsel == 2) ? 1'($urandom_range(1, 0)) : zsel[0];
      #1;
      e = expect_out(op, fn, k, zero);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ctrl_vector op=%0d funct=%0d cycle=%0d zero=%0b got=%h exp=%h",
                 op, fn, k, zero, obs, e);
      end
      checks++;
      if (wren === 1'b1 && regwrite === 1'b1) begin
        errors++;
        $display("FAIL strobe_overlap op=%0d cycle=%0d got wren=1 regwrite=1 exp not both", op, k);
      end
      n_wr   += (wren === 1'b1) ? 1 : 0;
      n_rw   += (regwrite === 1'b1) ? 1 : 0;
      n_done += (instr_done === 1'b1) ? 1 : 0;
      n_ill  += (illegal === 1'b1) ? 1 : 0;
    end
    checks++;
    if (n_wr != ((c == C_SW) ? 1 : 0) || n_rw != ((c == C_LW || c == C_R || c == C_I) ? 1 : 0)) begin
      errors++;
      $display("FAIL strobe_count op=%0d funct=%0d got wren=%0d regwrite=%0d", op, fn, n_wr, n_rw);
    end
    checks++;
    if (n_done != ((c == C_ILL) ? 0 : 1) || n_ill != ((c == C_ILL) ? 1 : 0)) begin
      errors++;
      $display("FAIL done_count op=%0d funct=%0d got done=%0d illegal=%0d", op, fn, n_done, n_ill);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, outs_t'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_instr(6'd0, 6'd32, 2);
    run_instr(6'd0, 6'd34, 2);
    run_instr(6'd0, 6'd42, 2);
  endtask

  task automatic test_mem();
    run_instr(6'd35, 6'($urandom), 2);
    run_instr(6'd43, 6'($urandom), 2);
  endtask

  task automatic test_branch();
    run_instr(6'd4, 6'd0, 1);
    run_instr(6'd4, 6'd0, 0);
    run_instr(6'd5, 6'd0, 1);
    run_instr(6'd5, 6'd0, 0);
    run_instr(6'd2, 6'd0, 2);
  endtask

  task automatic test_illegal();
    run_instr(6'd63, 6'd32, 2);
    run_instr(6'd0, 6'd0, 2);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        Op = 6'd43;
        funct = 6'd0;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_in_memwr got=%h exp=%h (wren=%0b)", obs, outs_t'(0), wren);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", obs, outs_t'(0));
    end
    rst = 1'b0;
    run_instr(6'd8, 6'd0, 2);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10];
    logic [5:0] fns [4];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd9, 6'd12, 6'd4, 6'd5, 6'd2, 6'd0};
    fns = '{6'd32, 6'd34, 6'd42, 6'd0};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(9, 0)];
      if (i % 7 == 6) op = 6'($urandom);
      fn = fns[$urandom_range(3, 0)];
      if (i % 5 == 4) fn = 6'($urandom);
      run_instr(op, fn, 2);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    run_instr(6'd0, 6'd32, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
